// File: rtl/card_pkg.sv
// Shared card types for the shoe, hand controllers and display logic.
// Also holds the shoe FSM encoding and small deck helpers.
package card_pkg;

  typedef enum logic [1:0] {CLUBS, DIAMONDS, HEARTS, SPADES} suit_t;

  typedef struct packed {
    suit_t      suit;
    logic [3:0] rank;
  } card_t;

  localparam logic [3:0] RANK_ACE  = 4'd1;
  localparam logic [3:0] RANK_KING = 4'd13;
  localparam int         DECK_SIZE = 52;
  localparam logic [5:0] LAST_IDX  = 6'd51;

  typedef enum logic [1:0] {S_INIT, S_SHUFFLE, S_READY, S_EMPTY} shoe_state_t;

  // Card stored at deck position k before shuffling: suit = k/13, rank = k%13 + 1.
  function automatic card_t init_card(input logic [5:0] k);
    card_t      c;
    logic [5:0] q;
    logic [5:0] r;
    q      = k / 6'd13;
    r      = k - q * 6'd13;
    c.suit = suit_t'(q[1:0]);
    c.rank = r[3:0] + RANK_ACE;
    return c;
  endfunction

  // Smallest 2^n-1 covering i, so a masked random index is accepted >=50% of the time.
  function automatic logic [5:0] swap_mask(input logic [5:0] i);
    logic [5:0] m;
    if (i <= 6'd1)       m = 6'd1;
    else if (i <= 6'd3)  m = 6'd3;
    else if (i <= 6'd7)  m = 6'd7;
    else if (i <= 6'd15) m = 6'd15;
    else if (i <= 6'd31) m = 6'd31;
    else                 m = 6'd63;
    return m;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 16'hB400); a zero seed is replaced by 16'h0001.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [15:0] o_value
);

  localparam logic [15:0] TAPS      = 16'hB400;
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q[0] ? ((value_q >> 1) ^ TAPS) : (value_q >> 1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) value_q <= SEED_SAFE;
    else         value_q <= value_d;
  end

  assign o_value = value_q;

endmodule

// File: rtl/card_shoe.sv
// Single-deck card shoe: fills the deck in order, Fisher-Yates shuffles it with an LFSR,
// then serves one card per accepted draw and reports how many cards remain.
module card_shoe
  import card_pkg::*;
#(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          LOW_SHOE = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_draw_req,
  input  logic       i_shuffle_req,
  output card_t      o_card,
  output logic       o_card_valid,
  output logic       o_ready,
  output logic [5:0] o_cards_left,
  output logic       o_low_shoe,
  output logic       o_draw_err
);

  shoe_state_t state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  ptr_q, ptr_d;
  card_t       card_q, card_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // Plain register array: a swap needs two reads and two writes in one cycle.
  card_t       deck_q [DECK_SIZE];
  card_t       deck_d [DECK_SIZE];

  logic [15:0] lfsr_value;
  logic [5:0]  swap_j;
  card_t       card_at_i;
  card_t       card_at_j;
  logic        init_we;
  logic        swap_we;
  logic        dealing;
  logic [5:0]  cards_left;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_value (lfsr_value)
  );

  assign swap_j    = lfsr_value[5:0] & swap_mask(idx_q);
  assign card_at_i = deck_q[idx_q];
  assign card_at_j = deck_q[swap_j];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    card_d  = card_q;
    valid_d = 1'b0;
    err_d   = i_draw_req && ((state_q != S_READY) || i_shuffle_req);
    init_we = 1'b0;
    swap_we = 1'b0;
    if (i_shuffle_req) begin
      state_d = S_INIT;
      idx_d   = '0;
      ptr_d   = '0;
    end else begin
      case (state_q)
        S_INIT: begin
          init_we = 1'b1;
          if (idx_q == LAST_IDX) state_d = S_SHUFFLE;
          else                   idx_d   = idx_q + 6'd1;
        end
        S_SHUFFLE: begin
          // Out-of-range j is rejected; the LFSR offers a fresh value next cycle.
          if (swap_j <= idx_q) begin
            swap_we = 1'b1;
            if (idx_q == 6'd1) begin
              ptr_d   = '0;
              state_d = S_READY;
            end else begin
              idx_d = idx_q - 6'd1;
            end
          end
        end
        S_READY: begin
          if (i_draw_req) begin
            card_d  = deck_q[ptr_q];
            valid_d = 1'b1;
            ptr_d   = ptr_q + 6'd1;
            if (ptr_q == LAST_IDX) state_d = S_EMPTY;
          end
        end
        S_EMPTY: ;
        default: state_d = S_INIT;
      endcase
    end
  end

  always_comb begin
    deck_d = deck_q;
    if (init_we) begin
      deck_d[idx_q] = init_card(idx_q);
    end else if (swap_we) begin
      deck_d[idx_q]  = card_at_j;
      deck_d[swap_j] = card_at_i;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      ptr_q   <= '0;
      card_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      card_q  <= card_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Deck contents need no reset: every entry is rewritten by the init pass.
  always_ff @(posedge i_clk) begin
    deck_q <= deck_d;
  end

  assign dealing    = (state_q == S_READY) || (state_q == S_EMPTY);
  assign cards_left = dealing ? (6'(DECK_SIZE) - ptr_q) : 6'd0;

  assign o_card       = card_q;
  assign o_card_valid = valid_q;
  assign o_ready      = (state_q == S_READY);
  assign o_cards_left = cards_left;
  assign o_low_shoe   = dealing && (cards_left <= 6'(LOW_SHOE));
  assign o_draw_err   = err_q;

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: reset, full deal against a shuffle model, empty-shoe
// draws, a table of back-to-back/shuffle-collision cycles, and reset reproducibility.
module tb_card_shoe;
  import card_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk;
  logic       reset;
  logic       draw_req;
  logic       shuffle_req;
  card_t      card;
  logic       card_valid;
  logic       ready;
  logic [5:0] cards_left;
  logic       low_shoe;
  logic       draw_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] model_deck [52];
  logic [5:0] dealt      [52];
  logic [5:0] first_order[52];
  logic       seen       [64];

  typedef struct {
    logic       draw;
    logic       shuf;
    logic       exp_valid;
    logic       exp_err;
    logic       exp_ready;
    logic [5:0] exp_left;
    logic       exp_low;
  } vec_t;

  vec_t vecs[$];

  card_shoe #(.SEED(SEED), .LOW_SHOE(10)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_draw_req    (draw_req),
    .i_shuffle_req (shuffle_req),
    .o_card        (card),
    .o_card_valid  (card_valid),
    .o_ready       (ready),
    .o_cards_left  (cards_left),
    .o_low_shoe    (low_shoe),
    .o_draw_err    (draw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int mask_of(input int i);
    if (i <= 1)  return 1;
    if (i <= 3)  return 3;
    if (i <= 7)  return 7;
    if (i <= 15) return 15;
    if (i <= 31) return 31;
    return 63;
  endfunction

  // Expected first deal after reset: 52 init steps, then Fisher-Yates with rejection.
  task automatic build_model();
    logic [15:0] lf;
    logic [5:0]  tmp;
    int          i;
    int          j;
    for (int k = 0; k < 52; k++) model_deck[k] = {2'(k / 13), 4'(k % 13 + 1)};
    lf = SEED;
    repeat (52) lf = lfsr_step(lf);
    i = 51;
    while (1) begin
      j = int'(lf[5:0]) & mask_of(i);
      if (j <= i) begin
        tmp           = model_deck[i];
        model_deck[i] = model_deck[j];
        model_deck[j] = tmp;
        if (i == 1) break;
        i--;
      end
      lf = lfsr_step(lf);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_card"},  int'(card),       0);
    check({tag, "_valid"}, int'(card_valid), 0);
    check({tag, "_ready"}, int'(ready),      0);
    check({tag, "_left"},  int'(cards_left), 0);
    check({tag, "_low"},   int'(low_shoe),   0);
    check({tag, "_err"},   int'(draw_err),   0);
  endtask

  task automatic wait_ready(input string tag);
    int cnt;
    bit saw_valid;
    cnt       = 0;
    saw_valid = 0;
    while (!ready && cnt < 2000) begin
      tick();
      if (card_valid) saw_valid = 1;
      cnt++;
    end
    check({tag, "_ready_in_budget"}, int'(ready), 1);
    check({tag, "_no_valid_busy"}, int'(saw_valid), 0);
    check({tag, "_left52"}, int'(cards_left), 52);
    check({tag, "_low0"}, int'(low_shoe), 0);
  endtask

  // Releases reset, pokes a draw during init, waits for the shoe, then deals 52 pulsed draws.
  task automatic run_from_reset(input string tag);
    int rank_cnt[16];
    int suit_cnt[4];
    @(negedge clk);
    reset = 1'b0;
    tick(); tick(); tick();
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    check({tag, "_init_draw_err"}, int'(draw_err), 1);
    check({tag, "_init_draw_valid"}, int'(card_valid), 0);
    tick();
    check({tag, "_init_err_clear"}, int'(draw_err), 0);
    wait_ready(tag);
    for (int r = 0; r < 16; r++) rank_cnt[r] = 0;
    for (int s = 0; s < 4; s++) suit_cnt[s] = 0;
    for (int k = 0; k < 52; k++) begin
      draw_req = 1'b1;
      tick();
      draw_req = 1'b0;
      check({tag, "_deal_valid"}, int'(card_valid), 1);
      check({tag, "_deal_card"}, int'(card), int'(model_deck[k]));
      check({tag, "_deal_left"}, int'(cards_left), 51 - k);
      check({tag, "_deal_low"}, int'(low_shoe), (51 - k <= 10) ? 1 : 0);
      check({tag, "_deal_ready"}, int'(ready), (k < 51) ? 1 : 0);
      dealt[k] = card;
      rank_cnt[card.rank]++;
      suit_cnt[int'(card.suit)]++;
      tick();
      check({tag, "_deal_strobe_1cyc"}, int'(card_valid), 0);
    end
    for (int r = 1; r <= int'(RANK_KING); r++) check({tag, "_rank_count"}, rank_cnt[r], 4);
    for (int s = 0; s < 4; s++) check({tag, "_suit_count"}, suit_cnt[s], 13);
  endtask

  task automatic add_vec(input logic d, input logic s, input logic v, input logic e,
                         input logic r, input int left, input logic low);
    vec_t t;
    t.draw = d; t.shuf = s; t.exp_valid = v; t.exp_err = e;
    t.exp_ready = r; t.exp_left = 6'(left); t.exp_low = low;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    int distinct;

    for (int n = 0; n < 5; n++)  add_vec(1, 0, 1, 0, 1, 51 - n, 0);
    add_vec(0, 0, 0, 0, 1, 47, 0);
    for (int n = 0; n < 15; n++) add_vec(1, 0, 1, 0, 1, 46 - n, 0);
    add_vec(1, 1, 0, 1, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0);

    build_model();

    reset       = 1'b1;
    draw_req    = 1'b0;
    shuffle_req = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");

    run_from_reset("first");
    for (int k = 0; k < 52; k++) first_order[k] = dealt[k];

    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    check("empty_draw_err", int'(draw_err), 1);
    check("empty_draw_valid", int'(card_valid), 0);
    check("empty_card_hold", int'(card), int'(model_deck[51]));
    check("empty_ready", int'(ready), 0);
    check("empty_left", int'(cards_left), 0);
    check("empty_low", int'(low_shoe), 1);
    tick();
    check("empty_err_1cyc", int'(draw_err), 0);

    shuffle_req = 1'b1;
    tick();
    shuffle_req = 1'b0;
    check("reshuf_ready", int'(ready), 0);
    check("reshuf_left", int'(cards_left), 0);
    wait_ready("reshuf");

    for (int s = 0; s < 64; s++) seen[s] = 1'b0;
    foreach (vecs[n]) begin
      draw_req    = vecs[n].draw;
      shuffle_req = vecs[n].shuf;
      tick();
      draw_req    = 1'b0;
      shuffle_req = 1'b0;
      check("vec_valid", int'(card_valid), int'(vecs[n].exp_valid));
      check("vec_err",   int'(draw_err),   int'(vecs[n].exp_err));
      check("vec_ready", int'(ready),      int'(vecs[n].exp_ready));
      check("vec_left",  int'(cards_left), int'(vecs[n].exp_left));
      check("vec_low",   int'(low_shoe),   int'(vecs[n].exp_low));
      if (vecs[n].exp_valid && card_valid) begin
        check("vec_rank_range", int'(card.rank >= RANK_ACE && card.rank <= RANK_KING), 1);
        check("vec_no_duplicate", int'(seen[card]), 0);
        seen[card] = 1'b1;
      end
    end

    wait_ready("collide");
    for (int s = 0; s < 64; s++) seen[s] = 1'b0;
    distinct = 0;
    draw_req = 1'b1;
    for (int k = 0; k < 52; k++) begin
      tick();
      check("b2b_valid", int'(card_valid), 1);
      check("b2b_left", int'(cards_left), 51 - k);
      if (card.rank >= RANK_ACE && card.rank <= RANK_KING && !seen[card]) distinct++;
      seen[card] = 1'b1;
    end
    draw_req = 1'b0;
    check("perm_distinct", distinct, 52);
    tick();
    check("b2b_ready_after", int'(ready), 0);
    check("b2b_valid_after", int'(card_valid), 0);

    shuffle_req = 1'b1;
    tick();
    shuffle_req = 1'b0;
    repeat (60) tick();
    check("midshuffle_busy", int'(ready), 0);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    tick(); tick();

    run_from_reset("second");
    mism = 0;
    for (int k = 0; k < 52; k++) if (dealt[k] !== first_order[k]) mism++;
    check("repeat_order_mismatches", mism, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
